// File: rtl/crf_lut_pkg.sv
// Shared types and helpers for the multi-channel CRF lookup table.
// Identity curve and packed-field indexing live here.
package crf_lut_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    SWAP_PEND
  } state_e;

  function automatic logic [31:0] crf_ident(
    logic [31:0] addr,
    int          in_w,
    int          out_w
  );
    return addr << (out_w - in_w);
  endfunction

  function automatic int fld_lo(int c, int w);
    return c * w;
  endfunction

endpackage

// File: rtl/crf_lut_bank.sv
// One channel's double-buffered CRF table: two 2^IN_W x OUT_W banks,
// synchronous write port and registered read port.
module crf_lut_bank #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic             wboth_i,
  input  logic             wbank_i,
  input  logic [IN_W-1:0]  waddr_i,
  input  logic [OUT_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic             rbank_i,
  input  logic [IN_W-1:0]  raddr_i,
  output logic [OUT_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << IN_W;

  logic [OUT_W-1:0] mem0_q [DEPTH];
  logic [OUT_W-1:0] mem1_q [DEPTH];
  logic [OUT_W-1:0] rdata_q;

  // Table storage survives reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we_i && (wboth_i || !wbank_i)) begin
      mem0_q[waddr_i] <= wdata_i;
    end
    if (we_i && (wboth_i || wbank_i)) begin
      mem1_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rbank_i ? mem1_q[raddr_i]
                         : mem0_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/crf_lut_mc.sv
// Multi-channel runtime-loadable CRF LUT with shadow-bank swap.
// CRF_LUT_INIT_EN: load identity curve into all banks after reset.
module crf_lut_mc
  import crf_lut_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int CH    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  in_valid,
  input  logic [CH*IN_W-1:0]    pixel,
  output logic                  out_valid,
  output logic [CH*OUT_W-1:0]   data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [$clog2(CH)-1:0] ld_ch,
  input  logic [IN_W-1:0]       ld_addr,
  input  logic [OUT_W-1:0]      ld_data,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  active_bank
);

  state_e state_q, state_d;

  logic                 s1_valid_q;
  logic [CH*IN_W-1:0]   s1_pix_q;
  logic                 out_valid_q;
  logic                 active_bank_q;
  logic                 swap_done_q;

  logic                 ld_fire;
  logic                 swap_fire;
  logic                 pipe_empty;
  logic                 init_we;
  logic                 init_last;
  logic [IN_W-1:0]      init_addr;
  logic [IN_W-1:0]      waddr;
  logic [OUT_W-1:0]     wdata;

`ifdef CRF_LUT_INIT_EN
  localparam state_e RST_ST = INIT;

  logic [IN_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign init_we   = (state_q == INIT);
  assign init_addr = cnt_q;
  assign init_last = &cnt_q;
`else
  localparam state_e RST_ST = RUN;

  assign init_we   = 1'b0;
  assign init_addr = '0;
  assign init_last = 1'b0;
`endif

  assign ld_ready = (state_q == RUN);
  assign ld_fire  = ld_valid && ld_ready
                 && (int'(ld_ch) < CH);

  // Nothing in flight and nothing entering this cycle.
  assign pipe_empty = !s1_valid_q && !out_valid_q
                   && !(in_valid && clk_en);
  assign swap_fire  = (state_q == SWAP_PEND) && pipe_empty;

  assign waddr = init_we ? init_addr : ld_addr;
  assign wdata = init_we
               ? OUT_W'(crf_ident(32'(init_addr), IN_W, OUT_W))
               : ld_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:      if (init_last) state_d = RUN;
      RUN:       if (swap_req)  state_d = SWAP_PEND;
      SWAP_PEND: if (swap_fire) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_ST;
      s1_valid_q    <= 1'b0;
      s1_pix_q      <= '0;
      out_valid_q   <= 1'b0;
      active_bank_q <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      swap_done_q <= swap_fire;
      if (swap_fire) begin
        active_bank_q <= ~active_bank_q;
      end
      if (clk_en) begin
        s1_valid_q  <= in_valid && (state_q != INIT);
        s1_pix_q    <= pixel;
        out_valid_q <= s1_valid_q;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    crf_lut_bank #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (init_we || (ld_fire && (int'(ld_ch) == c))),
      .wboth_i (init_we),
      .wbank_i (~active_bank_q),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (clk_en),
      .rbank_i (active_bank_q),
      .raddr_i (s1_pix_q[fld_lo(c, IN_W) +: IN_W]),
      .rdata_o (data[fld_lo(c, OUT_W) +: OUT_W])
    );
  end

  assign out_valid   = out_valid_q;
  assign swap_done   = swap_done_q;
  assign active_bank = active_bank_q;

endmodule

// File: tb/tb_crf_lut_mc.sv
// Randomized bench for crf_lut_mc against a table/queue reference model.
// Builds with or without CRF_LUT_INIT_EN.
module tb_crf_lut_mc;

  localparam int IN_W  = 5;
  localparam int OUT_W = 8;
  localparam int CH    = 3;
  localparam int DEPTH = 1 << IN_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clk_en = 1'b0;
  logic                in_valid = 1'b0;
  logic [CH*IN_W-1:0]  pixel = '0;
  logic                out_valid;
  logic [CH*OUT_W-1:0] data;
  logic                ld_valid = 1'b0;
  logic                ld_ready;
  logic [1:0]          ld_ch = '0;
  logic [IN_W-1:0]     ld_addr = '0;
  logic [OUT_W-1:0]    ld_data = '0;
  logic                swap_req = 1'b0;
  logic                swap_done;
  logic                active_bank;

  always #5 clk = ~clk;

  crf_lut_mc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CH    (CH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .in_valid    (in_valid),
    .pixel       (pixel),
    .out_valid   (out_valid),
    .data        (data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_ch       (ld_ch),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .active_bank (active_bank)
  );

  logic [OUT_W-1:0]    tbl [2][CH][DEPTH];
  bit                  mbank;
  bit                  pend;
  logic [CH*OUT_W-1:0] exp_q [$];
  int                  n_chk;
  int                  n_pass;
  int                  n_swap;
  int                  n_out;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [CH*OUT_W-1:0] lookup(logic [CH*IN_W-1:0] p);
    logic [CH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*OUT_W +: OUT_W] = tbl[mbank][c][p[c*IN_W +: IN_W]];
    return r;
  endfunction

  function automatic logic [CH*IN_W-1:0] pk(int a0, int a1, int a2);
    logic [IN_W-1:0] f0, f1, f2;
    f0 = a0[IN_W-1:0];
    f1 = a1[IN_W-1:0];
    f2 = a2[IN_W-1:0];
    return {f2, f1, f0};
  endfunction

  // Output monitor: pops the expectation queue on every enabled edge.
  logic                en_e, rst_e, pv;
  logic [CH*OUT_W-1:0] pd;
  always @(posedge clk) begin
    en_e  = clk_en;
    rst_e = rst_n;
    pd    = data;
    pv    = out_valid;
    #1;
    if (rst_e && rst_n) begin
      if (en_e) begin
        if (out_valid) begin
          if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
          else begin
            chk("data", data, exp_q.pop_front());
            n_out++;
          end
        end
      end else begin
        chk("hold_data", data, pd);
        chk("hold_valid", out_valid, pv);
      end
    end
  end

  task automatic cycle(input bit iv, input logic [CH*IN_W-1:0] pix,
                       input bit en, input bit lv, input int lch,
                       input int la, input int ld, input bit sreq);
    in_valid = iv;
    pixel    = pix;
    clk_en   = en;
    ld_valid = lv;
    ld_ch    = lch[1:0];
    ld_addr  = la[IN_W-1:0];
    ld_data  = ld[OUT_W-1:0];
    swap_req = sreq;
    chk("ld_ready", ld_ready, !pend);
    if (iv && en) exp_q.push_back(lookup(pix));
    if (lv && !pend && lch < CH) tbl[!mbank][lch][la] = ld[OUT_W-1:0];
    if (sreq && !pend) pend = 1;
    @(negedge clk);
    if (swap_done) begin
      chk("swap_when_pend", pend, 1);
      chk("swap_drained", exp_q.size(), 0);
      mbank = !mbank;
      pend  = 0;
      n_swap++;
    end
    chk("active_bank", active_bank, mbank);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, '0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_swap();
    for (int i = 0; i < 30 && pend; i++) idle(1);
    if (pend) chk("swap_timeout", pend, 0);
  endtask

  task automatic do_swap();
    cycle(0, '0, 1, 0, 0, 0, 0, 1);
    wait_swap();
  endtask

  task automatic init_wait();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1;
      clk_en   = 1;
      pixel    = CH*IN_W'($urandom);
      if (i == DEPTH - 1) chk("init_ready_low", ld_ready, 0);
      @(negedge clk);
    end
    in_valid = 0;
    chk("init_ready_high", ld_ready, 1);
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < DEPTH; a++)
          tbl[b][c][a] = OUT_W'(a << (OUT_W - IN_W));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_active_bank", active_bank, 0);
    chk("rst_swap_done", swap_done, 0);
`ifdef CRF_LUT_INIT_EN
    chk("rst_ld_ready", ld_ready, 0);
`else
    chk("rst_ld_ready", ld_ready, 1);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s0, o0;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1;
`ifdef CRF_LUT_INIT_EN
    init_wait();
    cycle(1, pk(5'h1F, 5'h01, 5'h10), 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("init_identity", data, 24'h8008F8);
    idle(1);
`else
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < CH; c++)
        for (int a = 0; a < DEPTH; a++)
          cycle(0, '0, 1, 1, c, a, int'($urandom_range(255)), 0);
      do_swap();
    end
`endif
    // Directed load then swap.
    cycle(0, '0, 1, 1, 0, 1, 8'h09, 0);
    cycle(0, '0, 1, 1, 2, 5'h1F, 8'h51, 0);
    s0 = n_swap;
    do_swap();
    chk("directed_swap", n_swap, s0 + 1);
    cycle(1, pk(1, 0, 5'h1F), 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("ld_ch0", data[7:0], 8'h09);
    chk("ld_ch2", data[23:16], 8'h51);
    idle(1);

    // Swap requested mid-stream; write accepted alongside the request.
    s0 = n_swap;
    for (int i = 0; i < 10; i++) begin
      cycle(1, CH*IN_W'($urandom), 1, (i == 4 || i == 6),
            1, 7, (i == 4) ? 8'h3C : 8'hEE, (i == 4));
      if (i == 6) chk("pend_ld_ready", ld_ready, 0);
    end
    chk("no_early_swap", n_swap, s0);
    wait_swap();
    idle(2);
    chk("stream_swap_once", n_swap, s0 + 1);
    cycle(1, pk(0, 7, 0), 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("same_cycle_write", data[15:8], 8'h3C);
    idle(1);

    // clk_en dropped for 5 cycles mid-stream.
    o0 = n_out;
    for (int i = 0; i < 13; i++)
      cycle(1, CH*IN_W'($urandom), !(i >= 4 && i < 9), 0, 0, 0, 0, 0);
    idle(3);
    chk("en_count", n_out - o0, 8);
    chk("en_drained", exp_q.size(), 0);

    // Out-of-range channel write is discarded.
    for (int a = 0; a < 4; a++) cycle(0, '0, 1, 1, 3, a * 9, 8'hA5, 0);
    do_swap();
    for (int a = 0; a < DEPTH; a++) cycle(1, pk(a, a, a), 1, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(1), CH*IN_W'($urandom), $urandom_range(3) != 0,
            $urandom_range(2) == 0, int'($urandom_range(3)),
            int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)),
            $urandom_range(15) == 0);
    wait_swap();
    idle(3);
    chk("rand_drained", exp_q.size(), 0);

    // Reset while a swap is pending and pixels are in flight.
    if (!mbank) do_swap();
    cycle(1, CH*IN_W'($urandom), 1, 0, 0, 0, 0, 1);
    cycle(1, CH*IN_W'($urandom), 1, 0, 0, 0, 0, 0);
    chk("pre_rst_bank", active_bank, 1);
    rst_n = 0;
    in_valid = 0;
    swap_req = 0;
    exp_q.delete();
    pend  = 0;
    mbank = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1;
`ifdef CRF_LUT_INIT_EN
    init_wait();
`endif
    for (int a = 0; a < DEPTH; a++)
      cycle(1, pk(a, DEPTH - 1 - a, a), 1, 0, 0, 0, 0, 0);
    idle(4);
    chk("post_rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/crf_lut_mc.md
# crf_lut_mc

Multi-channel, runtime-loadable camera-response-function (CRF) lookup table for the HDR pipeline. It replaces the fixed per-colour ROMs with one parametrised block serving CH colour channels. Each channel has double-buffered table storage: firmware loads the shadow bank through a load port, then requests a glitch-free bank swap that takes effect only when the pixel pipeline is empty. The block sits between pixel unpacking and the HDR weighting/merge stage.

## Interface
- IN_W, 5, pixel code width per channel (table depth 2^IN_W)
- OUT_W, 8, response value width per channel (OUT_W ≥ IN_W)
- CH, 3, number of colour channels
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  pixel-pipeline enable; load and swap logic ignore it
- in_valid  in  1  pixel word valid
- pixel  in  CH*IN_W  packed codes, channel 0 in LSBs
- out_valid  out  1  data valid
- data  out  CH*OUT_W  packed response values, channel 0 in LSBs
- ld_valid  in  1  table write request
- ld_ready  out  1  table write accepted when high with ld_valid
- ld_ch  in  $clog2(CH)  target channel; values ≥ CH are accepted and discarded
- ld_addr  in  IN_W  table address
- ld_data  in  OUT_W  table value
- swap_req  in  1  single-cycle request to swap active and shadow banks
- swap_done  out  1  single-cycle pulse when the swap takes effect
- active_bank  out  1  bank currently used for lookups

## Operation
- States: INIT, RUN, SWAP_PEND.
- Reset enters INIT if CRF_LUT_INIT_EN is defined. Otherwise reset enters RUN.
- RUN: ld_ready=1. An accepted write stores ld_data at [shadow bank][ld_ch][ld_addr].
- On swap_req, the block moves to SWAP_PEND. A write accepted in the same cycle as swap_req completes before the swap.
- SWAP_PEND: ld_ready=0 and further swap_req pulses are ignored.
- The swap executes on the first cycle in which both pipeline stages hold no valid pixel and in_valid=0 (or clk_en=0 with both stages empty). That cycle toggles active_bank, pulses swap_done and returns to RUN.
- Lookup pipeline, advancing only on clk_en=1:
  - Stage 1 registers pixel and in_valid.
  - Stage 2 registers the table reads from active_bank for all channels, plus valid.
- With clk_en=0, all pipeline registers, data and out_valid hold their values.

## Timing
- Reset values: out_valid=0, data=0, active_bank=0, swap_done=0. ld_ready=0 with the init feature, 1 without it.
- Lookup latency is 2 enabled cycles from in_valid to out_valid. Throughput is one pixel per enabled cycle.
- Table writes are visible to lookups only after a swap. The active bank is never written.
- swap_done is high for exactly one cycle. active_bank changes in that same cycle.
- The first lookup after a swap is the first in_valid accepted after swap_done, and it reads the new bank.
- Asserting rst_n low mid-load or mid-swap aborts the operation. active_bank returns to 0 and a pending swap is lost. Table contents are preserved without the init feature and rewritten with it.

## Configuration
- CRF_LUT_INIT_EN defined:
  - After reset the INIT state walks a counter over 0..2^IN_W-1, one address per cycle.
  - Each cycle writes the identity curve, addr << (OUT_W-IN_W), to both banks of all channels.
  - During INIT: ld_ready=0, swap_req is ignored, in_valid is dropped and out_valid=0.
  - The block enters RUN and raises ld_ready on the cycle after the last write, 2^IN_W cycles after reset release.
- CRF_LUT_INIT_EN undefined: no INIT state and no init counter. Table contents are undefined until firmware loads them.

## Structure
- Package crf_lut_pkg holds:
  - the state enum (INIT, RUN, SWAP_PEND);
  - the identity-curve function;
  - the packed-field index helpers for channel c.
- Sub-module crf_lut_bank, instantiated CH times: one channel's two 2^IN_W×OUT_W banks. It has a synchronous write port (bank, addr, data) and a registered read port (bank, addr, enable).

## Test plan
- Init with IN_W=5, OUT_W=8, CH=3 and the init feature: reset release, wait 32 cycles. Pixel {5'h10,5'h01,5'h1F} → data {8'h80,8'h08,8'hF8} two cycles later.
- Load ch0 addr 1 = 8'h09 and ch2 addr 1F = 8'h51, then swap_req with the pipeline idle. swap_done pulses and active_bank=1. Pixel ch0=1, ch2=1F → 8'h09 and 8'h51.
- Issue swap_req during a 10-pixel back-to-back stream. The swap is deferred until the last out_valid has been produced and swap_done pulses once. ld_valid during SWAP_PEND sees ld_ready=0.
- Drop clk_en for 5 cycles mid-stream. data and out_valid hold. No pixel is lost or duplicated: 8 in → 8 out, in order.
- Write with ld_ch=3 (CH=3): accepted, and no table changes.
- Reset asserted in SWAP_PEND: active_bank=0, out_valid=0, no swap_done. The init sequence reruns.
